// File: rtl/md_ctrl_if.sv
// Bundle between E/D-stage pipeline control and the multiply/divide sequencer.
// The master side is the sequencer; the slave side is the pipeline and the HI/LO unit.
interface md_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             flush;
    logic             e_valid;
    logic [2:0]       e_md_op;
    logic             d_md_use;
    logic [2:0]       md_op;
    logic             md_start;
    logic             md_flush;
    logic             stall_d;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] perf_cnt;

    modport master (
        input  flush,
        input  e_valid,
        input  e_md_op,
        input  d_md_use,
        output md_op,
        output md_start,
        output md_flush,
        output stall_d,
        output busy,
        output err,
        output perf_cnt
    );

    modport slave (
        output flush,
        output e_valid,
        output e_md_op,
        output d_md_use,
        input  md_op,
        input  md_start,
        input  md_flush,
        input  stall_d,
        input  busy,
        input  err,
        input  perf_cnt
    );
endinterface

// File: rtl/md_ctrl.sv
// Sequencer between E-stage decode and the HI/LO multiply/divide unit.
// Define MD_PERF_CNT_EN to build the stall-cycle performance counter.
module md_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CNT_W    = 32
) (
    input  logic      clk,
    input  logic      reset,
    md_ctrl_if.master bus
);

    localparam int unsigned MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int unsigned LAT_W   = $clog2(MAX_LAT + 1);

    localparam logic [LAT_W-1:0] MULT_LOAD = LAT_W'(MULT_LAT);
    localparam logic [LAT_W-1:0] DIV_LOAD  = LAT_W'(DIV_LAT);
    localparam logic [LAT_W-1:0] CNT_ONE   = LAT_W'(1);

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    state_e           state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic       op_mul;
    logic       op_div;
    logic       op_hilo;
    logic       op_any;
    logic       issue;
    logic [2:0] md_op;
    logic       md_start;
    logic       busy;
    logic       stall_d;

    // Op decode; 111 falls into none of the classes and behaves like 000.
    always_comb begin
        op_mul  = (bus.e_md_op == 3'b001) || (bus.e_md_op == 3'b010);
        op_div  = (bus.e_md_op == 3'b011) || (bus.e_md_op == 3'b100);
        op_hilo = (bus.e_md_op == 3'b101) || (bus.e_md_op == 3'b110);
        op_any  = op_mul | op_div | op_hilo;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        issue    = 1'b0;
        md_op    = 3'b000;
        md_start = 1'b0;
        busy     = 1'b0;

        case (state_q)
            StIdle: begin
                issue    = bus.e_valid & ~bus.flush;
                md_start = issue & (op_mul | op_div);
                if (issue && op_any) begin
                    md_op = bus.e_md_op;
                end
                if (md_start) begin
                    state_d = StRun;
                    cnt_d   = op_mul ? MULT_LOAD : DIV_LOAD;
                end
            end

            StRun: begin
                busy = 1'b1;
                // The unit only holds one operation; a second MD op here is a hazard bug upstream.
                if (bus.e_valid && op_any) begin
                    err_d = 1'b1;
                end
                if (bus.flush || (cnt_q == CNT_ONE)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Issue cycle is included so a dependent D-stage instruction never slips past the start.
    assign stall_d = bus.d_md_use & (busy | md_start);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.md_op    = md_op;
    assign bus.md_start = md_start;
    assign bus.md_flush = bus.flush;
    assign bus.stall_d  = stall_d;
    assign bus.busy     = busy;
    assign bus.err      = err_q;

`ifdef MD_PERF_CNT_EN
    logic [CNT_W-1:0] perf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else if (stall_d) begin
            perf_q <= perf_q + CNT_W'(1);
        end
    end

    assign bus.perf_cnt = perf_q;
`else
    assign bus.perf_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_md_ctrl.sv
// Directed plus randomized bench for md_ctrl against a cycle-count reference model.
// Expected perf_cnt follows MD_PERF_CNT_EN the same way the design does.
module tb_md_ctrl;

    localparam int unsigned MULT_LAT = 5;
    localparam int unsigned DIV_LAT  = 10;
    localparam int unsigned CNT_W    = 32;

    logic clk = 1'b0;
    logic reset;

    md_ctrl_if #(.CNT_W(CNT_W)) bus ();

    md_ctrl #(
        .MULT_LAT(MULT_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model: remaining busy cycles, sticky error, stall count.
    int               rem;
    bit               err_m;
    logic [CNT_W-1:0] perf_m;

    // Last observed DUT flags, used for the cycle-count checks.
    logic obs_busy;
    logic obs_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model at the edge.
    task automatic step(input string tag, input logic rst, input logic fl, input logic ev,
                        input logic [2:0] op, input logic du);
        bit   in_run, is_md, is_any, iss, st, stall;
        logic [2:0] exp_op;
        reset        = rst;
        bus.flush    = fl;
        bus.e_valid  = ev;
        bus.e_md_op  = op;
        bus.d_md_use = du;
        #1;
        in_run = (rem > 0);
        is_md  = (op >= 3'd1) && (op <= 3'd4);
        is_any = (op >= 3'd1) && (op <= 3'd6);
        iss    = ev && !fl && !in_run;
        exp_op = (iss && is_any) ? op : 3'b000;
        st     = iss && is_md;
        stall  = du && (in_run || st);

        chk({tag, ".md_op"},    64'(bus.md_op),    64'(exp_op));
        chk({tag, ".md_start"}, 64'(bus.md_start), 64'(st));
        chk({tag, ".md_flush"}, 64'(bus.md_flush), 64'(fl));
        chk({tag, ".stall_d"},  64'(bus.stall_d),  64'(stall));
        chk({tag, ".busy"},     64'(bus.busy),     64'(in_run));
        chk({tag, ".err"},      64'(bus.err),      64'(err_m));
`ifdef MD_PERF_CNT_EN
        chk({tag, ".perf_cnt"}, 64'(bus.perf_cnt), 64'(perf_m));
`else
        chk({tag, ".perf_cnt"}, 64'(bus.perf_cnt), 64'(0));
`endif
        obs_busy  = bus.busy;
        obs_stall = bus.stall_d;

        @(posedge clk);
        if (rst) begin
            rem    = 0;
            err_m  = 1'b0;
            perf_m = '0;
        end else begin
            if (stall) perf_m = perf_m + 1'b1;
            if (in_run && ev && is_any) err_m = 1'b1;
            if (in_run) rem = fl ? 0 : rem - 1;
            else if (st) rem = (op <= 3'd2) ? int'(MULT_LAT) : int'(DIV_LAT);
        end
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input logic du);
        step(tag, 1'b0, 1'b0, 1'b0, 3'b000, du);
    endtask

    initial begin
        int busy_cnt;
        int stall_cnt;

        reset        = 1'b1;
        bus.flush    = 1'b0;
        bus.e_valid  = 1'b0;
        bus.e_md_op  = 3'b000;
        bus.d_md_use = 1'b0;
        rem          = 0;
        err_m        = 1'b0;
        perf_m       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        step("rst", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        idle("rst_idle", 1'b0);

        // 1: mult issue, busy for MULT_LAT cycles.
        step("t1_issue", 1'b0, 1'b0, 1'b1, 3'b010, 1'b0);
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            idle("t1_run", 1'b0);
            if (obs_busy) busy_cnt++;
        end
        chk("t1_busy_cycles", 64'(busy_cnt), 64'(MULT_LAT));

        // 2: divu with d_md_use held, stall for DIV_LAT+1 cycles.
        step("t2_rst", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        step("t2_issue", 1'b0, 1'b0, 1'b1, 3'b011, 1'b1);
        stall_cnt = obs_stall ? 1 : 0;
        for (int i = 0; i < 13; i++) begin
            idle("t2_run", 1'b1);
            if (obs_stall) stall_cnt++;
        end
        chk("t2_stall_cycles", 64'(stall_cnt), 64'(DIV_LAT + 1));
`ifdef MD_PERF_CNT_EN
        chk("t6_perf_before", 64'(bus.perf_cnt), 64'(DIV_LAT + 1));
`else
        chk("t6_perf_before", 64'(bus.perf_cnt), 64'(0));
`endif
        step("t6_rst", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        chk("t6_perf_after", 64'(bus.perf_cnt), 64'(0));

        // 3: mthi in IDLE passes op one cycle, no start, no stall.
        step("t3_mthi", 1'b0, 1'b0, 1'b1, 3'b101, 1'b1);
        idle("t3_after", 1'b1);

        // 4: div aborted by flush in its third RUN cycle.
        step("t4_issue", 1'b0, 1'b0, 1'b1, 3'b100, 1'b0);
        idle("t4_run1", 1'b0);
        idle("t4_run2", 1'b0);
        step("t4_flush", 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
        idle("t4_after", 1'b0);
        chk("t4_idle_after_flush", 64'(obs_busy), 64'(0));

        // 5: flush cancels same-cycle issue; MD op during RUN sets sticky err.
        step("t5_flush_issue", 1'b0, 1'b1, 1'b1, 3'b010, 1'b0);
        step("t5_issue", 1'b0, 1'b0, 1'b1, 3'b001, 1'b0);
        step("t5_clash", 1'b0, 1'b0, 1'b1, 3'b100, 1'b0);
        for (int i = 0; i < 8; i++) idle("t5_hold", 1'b0);
        chk("t5_err_sticky", 64'(bus.err), 64'(1));
        step("t5_invalid", 1'b0, 1'b0, 1'b1, 3'b111, 1'b1);
        step("t5_rst", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        chk("t5_err_cleared", 64'(bus.err), 64'(0));

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step("rnd",
                 ($urandom_range(63) == 0),
                 ($urandom_range(7) == 0),
                 1'($urandom_range(1)),
                 3'($urandom_range(7)),
                 1'($urandom_range(1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
